// File: rtl/write_logic_pkg.sv
// Shared FIFO configuration: default geometry and thresholds used by both the
// write-side and read-side controllers.
package write_logic_pkg;

   localparam int FIFO_MEM_SIZE  = 8;   // depth in words
   localparam int FIFO_WORD_SIZE = 12;  // data word width
   localparam int FIFO_PTR       = 3;   // address width, MEM_SIZE <= 2**PTR
   localparam int FIFO_AF_TH     = 6;   // almost-full at or above this count
   localparam int FIFO_AE_TH     = 2;   // almost-empty at or below this count

endpackage : write_logic_pkg

// File: rtl/write_logic_fifo_status.sv
// Occupancy counter and status-flag decode shared by both FIFO sides.
// The count moves by push - pop each edge and never goes below zero.
module fifo_status
   import write_logic_pkg::*;
#(
   parameter int MEM_SIZE = FIFO_MEM_SIZE,
   parameter int PTR      = FIFO_PTR,
   parameter int AF_TH    = FIFO_AF_TH,
   parameter int AE_TH    = FIFO_AE_TH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   output logic [PTR:0] count,
   output logic         fifo_full,
   output logic         fifo_empty,
   output logic         almost_full,
   output logic         almost_empty
);

   logic [PTR:0] r_count;
   logic [PTR:0] w_count_nxt;

   // Next occupancy: push and pop together cancel; a pop on an empty FIFO
   // without a matching push has nothing to remove and is ignored.
   always_comb begin
      // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
      w_count_nxt = r_count;
      if (push && !pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!push && pop && (r_count != '0)) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Occupancy register; reset discards everything held.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign count        = r_count;
   assign fifo_full    = (r_count == (PTR+1)'(MEM_SIZE));
   assign fifo_empty   = (r_count == '0);
   assign almost_full  = (r_count >= (PTR+1)'(AF_TH));
   assign almost_empty = (r_count <= (PTR+1)'(AE_TH));

endmodule : fifo_status

// File: rtl/write_logic.sv
// Write-side FIFO controller: accepts producer writes, drives the memory
// write address and enable, and records overflow/underflow events.
module write_logic
   import write_logic_pkg::*;
#(
   parameter int MEM_SIZE  = FIFO_MEM_SIZE,
   parameter int WORD_SIZE = FIFO_WORD_SIZE,
   parameter int PTR       = FIFO_PTR,
   parameter int AF_TH     = FIFO_AF_TH,
   parameter int AE_TH     = FIFO_AE_TH
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           fifo_wr,
   input  logic           fifo_rd,
   input  logic           pop,
   output logic [PTR-1:0] wr_ptr,
   output logic           push,
   output logic [PTR:0]   fifo_count,
   output logic           fifo_full,
   output logic           fifo_empty,
   output logic           almost_full,
   output logic           almost_empty,
   output logic           overflow_err,
   output logic           underflow_err
);

   // Reject geometries where the pointer cannot address every word.
   if ((WORD_SIZE < 1) || (MEM_SIZE < 1) || (MEM_SIZE > (2 ** PTR))) begin : g_bad_params
      $error("write_logic: invalid FIFO geometry");
   end

   logic [PTR-1:0] r_wr_ptr;
   logic           r_overflow_err;
   logic           r_underflow_err;
   logic           w_push;
   logic           w_overflow_evt;
   logic           w_underflow_evt;

   // A write is accepted when there is room, or when a simultaneous read frees
   // the slot; nothing is accepted while reset is held.
   assign w_push = !reset && fifo_wr && (!fifo_full || pop);

   // A dropped write and a read from an empty FIFO with no write to serve it.
   assign w_overflow_evt  = fifo_wr && fifo_full && !pop;
   assign w_underflow_evt = fifo_rd && fifo_empty && !fifo_wr;

   // Write pointer advances on each accepted write and wraps at the FIFO depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
      end else if (w_push) begin
         if (r_wr_ptr == PTR'(MEM_SIZE - 1)) begin
            r_wr_ptr <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
      end
   end

   // Sticky error flags: set by their event, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow_err  <= 1'b0;
         r_underflow_err <= 1'b0;
      end else begin
         if (w_overflow_evt) begin
            r_overflow_err <= 1'b1;
         end
         if (w_underflow_evt) begin
            r_underflow_err <= 1'b1;
         end
      end
   end

   fifo_status #(
      .MEM_SIZE (MEM_SIZE),
      .PTR      (PTR),
      .AF_TH    (AF_TH),
      .AE_TH    (AE_TH)
   ) u_fifo_status (
      .clk          (clk),
      .reset        (reset),
      .push         (w_push),
      .pop          (pop),
      .count        (fifo_count),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   assign wr_ptr        = r_wr_ptr;
   assign push          = w_push;
   assign overflow_err  = r_overflow_err;
   assign underflow_err = r_underflow_err;

endmodule : write_logic

// File: tb/tb_write_logic.sv
// Self-checking bench for write_logic: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_write_logic;
   import write_logic_pkg::*;

   localparam int MEM = FIFO_MEM_SIZE;
   localparam int P   = FIFO_PTR;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         fifo_wr = 1'b0;
   logic         fifo_rd = 1'b0;
   logic         pop = 1'b0;
   logic [P-1:0] wr_ptr;
   logic         push;
   logic [P:0]   fifo_count;
   logic         fifo_full, fifo_empty, almost_full, almost_empty;
   logic         overflow_err, underflow_err;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state (plain integers).
   int m_count = 0;
   int m_ptr = 0;
   bit m_ovf = 0;
   bit m_unf = 0;
   bit m_valid = 0;

   write_logic dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_wr       (fifo_wr),
      .fifo_rd       (fifo_rd),
      .pop           (pop),
      .wr_ptr        (wr_ptr),
      .push          (push),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_push();
      return !reset && fifo_wr && ((m_count != MEM) || pop);
   endfunction

   // Model advances on each rising edge from the inputs held across it.
   always @(posedge clk) begin
      bit p;
      p = model_push();
      if (reset) begin
         m_count = 0;
         m_ptr   = 0;
         m_ovf   = 0;
         m_unf   = 0;
         m_valid = 1;
      end else begin
         if (fifo_wr && (m_count == MEM) && !pop) m_ovf = 1;
         if (fifo_rd && (m_count == 0) && !fifo_wr) m_unf = 1;
         if (p) m_ptr = (m_ptr + 1) % MEM;
         if (p && !pop) m_count = m_count + 1;
         else if (!p && pop && (m_count > 0)) m_count = m_count - 1;
      end
   end

   // Compare process: every cycle, mid-low-phase, once inputs have settled.
   always @(negedge clk) begin
      #2;
      if (m_valid) begin
         check("push",          push,          int'(model_push()));
         check("wr_ptr",        wr_ptr,        m_ptr);
         check("fifo_count",    fifo_count,    m_count);
         check("fifo_full",     fifo_full,     int'(m_count == MEM));
         check("fifo_empty",    fifo_empty,    int'(m_count == 0));
         check("almost_full",   almost_full,   int'(m_count >= FIFO_AF_TH));
         check("almost_empty",  almost_empty,  int'(m_count <= FIFO_AE_TH));
         check("overflow_err",  overflow_err,  int'(m_ovf));
         check("underflow_err", underflow_err, int'(m_unf));
      end
   end

   // Drive one cycle of inputs at the falling edge, then let the compare run.
   task automatic cyc(input bit r, input bit wr, input bit rd, input bit p);
      @(negedge clk);
      reset   = r;
      fifo_wr = wr;
      fifo_rd = rd;
      pop     = p;
      #3;
   endtask

   initial begin
      // Reset, with a write request held to show push is suppressed.
      cyc(1, 1, 0, 0);
      check("lit_push_in_reset", push, 0);
      cyc(0, 0, 0, 0);
      check("lit_rst_count", fifo_count, 0);
      check("lit_rst_ptr", wr_ptr, 0);
      check("lit_rst_empty", fifo_empty, 1);
      check("lit_rst_ae", almost_empty, 1);
      check("lit_rst_full", fifo_full, 0);
      check("lit_rst_af", almost_full, 0);
      check("lit_rst_errs", {overflow_err, underflow_err}, 0);

      // Eight writes with no pops fill the FIFO.
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0);
         check("lit_fill_push", push, 1);
         check("lit_fill_count", fifo_count, i);
         check("lit_fill_ptr", wr_ptr, i);
         check("lit_fill_af", almost_full, int'(i >= 6));
      end
      cyc(0, 0, 0, 0);
      check("lit_full_count", fifo_count, 8);
      check("lit_full_ptr", wr_ptr, 0);
      check("lit_full_flag", fifo_full, 1);

      // Write while full with no pop is dropped and flagged.
      cyc(0, 1, 0, 0);
      check("lit_ovf_push", push, 0);
      check("lit_ovf_not_yet", overflow_err, 0);
      cyc(0, 0, 0, 0);
      check("lit_ovf_set", overflow_err, 1);
      check("lit_ovf_count", fifo_count, 8);
      check("lit_ovf_ptr", wr_ptr, 0);
      cyc(0, 0, 0, 0);
      check("lit_ovf_sticky", overflow_err, 1);

      // Refill from reset, then write and pop together while full.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 1);
      check("lit_full_wrpop_push", push, 1);
      cyc(0, 0, 0, 0);
      check("lit_full_wrpop_count", fifo_count, 8);
      check("lit_full_wrpop_ptr", wr_ptr, 1);
      check("lit_full_wrpop_ovf", overflow_err, 0);

      // Empty pass-through, then a lone read underflows.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 1);
      check("lit_pass_push", push, 1);
      cyc(0, 0, 0, 0);
      check("lit_pass_count", fifo_count, 0);
      check("lit_pass_unf", underflow_err, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      check("lit_unf_set", underflow_err, 1);
      check("lit_unf_count", fifo_count, 0);

      // Count 5, then a one-cycle reset while writing.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      check("lit_five_count", fifo_count, 5);
      cyc(1, 1, 0, 0);
      check("lit_midrst_push", push, 0);
      cyc(0, 0, 0, 0);
      check("lit_midrst_count", fifo_count, 0);
      check("lit_midrst_ptr", wr_ptr, 0);
      check("lit_midrst_errs", {overflow_err, underflow_err}, 0);
      check("lit_midrst_empty", fifo_empty, 1);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 50);
      end

      @(negedge clk);
      #4;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_write_logic
